// File: rtl/neighbor_req_gen.sv
// rtl/neighbor_req_gen.sv - expands a neighbor-list descriptor into per-entry bank/row read requests
// Optional macro NBR_REQ_PERF_CNT_EN adds saturating req_count / stall_count outputs.
module neighbor_req_gen #(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 10,
    parameter int NODE_W    = 10,
    parameter int LEN_W     = 8,
    localparam int BANK_W   = $clog2(NUM_BANKS),
    localparam int ADDR_W   = BANK_W + ROW_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              node_valid,
    output logic              node_ready,
    input  logic [NODE_W-1:0] node_id,
    input  logic [ADDR_W-1:0] nbr_base,
    input  logic [LEN_W-1:0]  nbr_len,
    input  logic              wfull,
    output logic              req_valid,
    output logic [BANK_W-1:0] req_bank,
    output logic [ROW_W-1:0]  req_row,
    output logic [NODE_W-1:0] req_node_id,
    output logic              req_last,
`ifdef NBR_REQ_PERF_CNT_EN
    output logic [31:0]       req_count,
    output logic [31:0]       stall_count,
`endif
    output logic              node_done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [NODE_W-1:0] id_q;
    logic              done_q;

    logic issuing;
    logic accept;
    logic is_last;
    logic zero_len;

    assign issuing    = (state == ST_ISSUE);
    assign node_ready = (state == ST_IDLE);
    assign accept     = node_valid && node_ready;
    assign zero_len   = (nbr_len == '0);
    assign is_last    = (remaining == LEN_W'(1));

    // The FIFO full flag gates the write strobe combinationally so no write lands on a full FIFO.
    assign req_valid = issuing && !wfull;
    assign req_last  = req_valid && is_last;

    assign req_bank    = issuing ? addr[BANK_W-1:0]      : '0;
    assign req_row     = issuing ? addr[ADDR_W-1:BANK_W] : '0;
    assign req_node_id = issuing ? id_q                  : '0;
    assign node_done   = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            id_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (req_valid && is_last) || (accept && zero_len);
            case (state)
                ST_IDLE: begin
                    if (accept && !zero_len) begin
                        addr      <= nbr_base;
                        remaining <= nbr_len;
                        id_q      <= node_id;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Address wraps naturally at the all-ones global address.
                    if (req_valid) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (is_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NBR_REQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_count   <= '0;
            stall_count <= '0;
        end else begin
            if (req_valid && (req_count != 32'hFFFF_FFFF)) begin
                req_count <= req_count + 32'd1;
            end
            if (issuing && wfull && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_neighbor_req_gen.sv
// tb/tb_neighbor_req_gen.sv - scoreboard bench for neighbor_req_gen
module tb_neighbor_req_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       node_valid = 1'b0;
    logic       node_ready;
    logic [9:0] node_id = '0;
    logic [11:0] nbr_base = '0;
    logic [7:0] nbr_len = '0;
    logic       wfull = 1'b0;
    logic       req_valid;
    logic [1:0] req_bank;
    logic [9:0] req_row;
    logic [9:0] req_node_id;
    logic       req_last;
    logic       node_done;
`ifdef NBR_REQ_PERF_CNT_EN
    logic [31:0] req_count;
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int zero_set = 0;
    int zero_seen = 0;
    logic prev_last = 1'b0;
    logic [22:0] exp_q[$];
    int pop_log[$];

    always #5 clk = ~clk;

    neighbor_req_gen dut (
        .clk        (clk),
        .reset      (reset),
        .node_valid (node_valid),
        .node_ready (node_ready),
        .node_id    (node_id),
        .nbr_base   (nbr_base),
        .nbr_len    (nbr_len),
        .wfull      (wfull),
        .req_valid  (req_valid),
        .req_bank   (req_bank),
        .req_row    (req_row),
        .req_node_id(req_node_id),
        .req_last   (req_last),
`ifdef NBR_REQ_PERF_CNT_EN
        .req_count  (req_count),
        .stall_count(stall_count),
`endif
        .node_done  (node_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every write and checks node_done timing.
    always @(negedge clk) begin
        logic exp_done;
        logic [22:0] e;
        cyc++;
        exp_done = prev_last;
        if (zero_set != zero_seen) begin
            exp_done = 1'b1;
            zero_seen = zero_set;
        end
        check("node_done", {31'd0, node_done}, {31'd0, exp_done});
        prev_last = 1'b0;
        if (req_valid) begin
            check("valid_while_wfull", {31'd0, wfull}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("req_fields", {9'd0, req_bank, req_row, req_node_id, req_last}, {9'd0, e});
                pop_log.push_back(cyc);
            end
            prev_last = req_last;
        end else if (node_ready) begin
            check("idle_outputs_zero", {9'd0, req_bank, req_row, req_node_id, req_last}, 32'd0);
        end
    end

    task automatic drive_desc(input logic [9:0] id, input logic [11:0] base, input logic [7:0] len);
        logic acc;
        logic [11:0] a;
        acc = 1'b0;
        node_valid = 1'b1;
        node_id = id;
        nbr_base = base;
        nbr_len = len;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            acc = node_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        node_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd1, 32'd0);
        end else if (len == 8'd0) begin
            zero_set++;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                a = base + 12'(i);
                exp_q.push_back({a[1:0], a[11:2], id, (i == int'(len) - 1)});
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !req_valid) break;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_node_done", {31'd0, node_done}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_node_ready", {31'd0, node_ready}, 32'd1);

        // Nominal burst: first request one cycle after accept, one per cycle.
        n0 = pop_log.size();
        drive_desc(10'h011, 12'h005, 8'd3);
        check("first_req_latency", {31'd0, req_valid}, 32'd1);
        wait_drain("nominal_drain");
        check("nominal_count", pop_log.size() - n0, 32'd3);
        check("nominal_tput", pop_log[n0 + 2] - pop_log[n0], 32'd2);

        // Wrap-around at the top of the address space.
        drive_desc(10'h022, 12'hFFE, 8'd4);
        wait_drain("wrap_drain");

        // Backpressure after the second request for three cycles.
        n0 = pop_log.size();
        drive_desc(10'h033, 12'h100, 8'd4);
        @(posedge clk);
        @(posedge clk);
        #1;
        wfull = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wfull = 1'b0;
        wait_drain("bp_drain");
        check("bp_writes", pop_log.size() - n0, 32'd4);
        check("bp_resume_gap", pop_log[n0 + 2] - pop_log[n0 + 1], 32'd4);

        // Zero-length descriptor: no request, done pulse, stays ready.
        n0 = pop_log.size();
        drive_desc(10'h044, 12'h200, 8'd0);
        check("zero_ready", {31'd0, node_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("zero_no_req", pop_log.size() - n0, 32'd0);

        // node_valid during ISSUE is ignored.
        drive_desc(10'h055, 12'h300, 8'd6);
        node_valid = 1'b1;
        node_id = 10'h3FF;
        nbr_base = 12'hABC;
        nbr_len = 8'd9;
        for (int i = 0; i < 3; i++) begin
            check("issue_not_ready", {31'd0, node_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        node_valid = 1'b0;
        wait_drain("ignore_drain");

        // Back-to-back descriptors: exactly one bubble.
        n0 = pop_log.size();
        drive_desc(10'h066, 12'h010, 8'd2);
        drive_desc(10'h077, 12'h020, 8'd2);
        wait_drain("b2b_drain");
        check("b2b_bubble", pop_log[n0 + 2] - pop_log[n0 + 1], 32'd2);

        // Reset mid-burst after the third request.
        n0 = pop_log.size();
        drive_desc(10'h088, 12'h040, 8'd8);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_req_valid", {31'd0, req_valid}, 32'd0);
        check("midrst_req_last", {31'd0, req_last}, 32'd0);
        check("midrst_bank_row", {20'd0, req_bank, req_row}, 32'd0);
        check("midrst_issued", pop_log.size() - n0, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_ready", {31'd0, node_ready}, 32'd1);
        n0 = pop_log.size();
        repeat (10) @(posedge clk);
        #1;
        check("postrst_no_req", pop_log.size() - n0, 32'd0);

`ifdef NBR_REQ_PERF_CNT_EN
        drive_desc(10'h099, 12'h080, 8'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        wfull = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wfull = 1'b0;
        wait_drain("perf_drain_a");
        drive_desc(10'h0AA, 12'h090, 8'd5);
        wait_drain("perf_drain_b");
        check("req_count", req_count, 32'd10);
        check("stall_count", stall_count, 32'd2);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
